// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_FAULT} state_e;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;
  function automatic logic [31:0] word_idx(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry instruction FIFO with flush; entry 0 is always the head
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] data_i,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_data_o,
  output logic [1:0]  count_o
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d, new_e;
  logic [1:0] count_q, count_d;
  logic wr_slot;
  always_comb begin
    new_e = {pc_i, data_i};
    wr_slot = (count_q - 2'(pop_i)) != 2'd0;
    e0_d = pop_i ? e1_q : e0_q;
    e1_d = e1_q;
    if (push_i && !wr_slot) e0_d = new_e;
    if (push_i && wr_slot) e1_d = new_e;
    count_d = flush_i ? 2'd0 : count_q + 2'(push_i) - 2'(pop_i);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i)
    assert (!(rst_ni && !flush_i && push_i && !pop_i && count_q == 2'(FETCH_DEPTH)));
  assign head_pc_o = e0_q.pc;
  assign head_data_o = e0_q.data;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and imem fetch controller with 2-entry output buffer
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tag_q, tag_d;
  logic inflight_q, inflight_d, fault_q, fault_d;
  logic pop, push, issue, in_range;
  logic [1:0] count, occ;
  fetch_buffer u_buf (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .pc_i       (tag_q),
    .data_i     (imem_rdata),
    .head_pc_o  (inst_pc),
    .head_data_o(inst_data),
    .count_o    (count)
  );
  // occupancy counts this cycle's pop so a steady stream issues every cycle
  always_comb begin
    pop = inst_valid & inst_ready;
    occ = count + 2'(inflight_q) - 2'(pop);
    in_range = word_idx(pc_q) < IMEM_DEPTH;
    state_d = state_q;
    fault_d = fault_q;
    issue = 1'b0;
    if (redirect_valid) begin
      state_d = halt_req ? S_HALT : S_RUN;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN:
          if (!in_range) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else if (halt_req) state_d = S_HALT;
          else issue = occ < 2'(FETCH_DEPTH);
        S_HALT: state_d = halt_req ? S_HALT : S_RUN;
        default: state_d = state_q;
      endcase
    end
    pc_d = redirect_valid ? redirect_pc : issue ? pc_q + PC_INC : pc_q;
    tag_d = issue ? pc_q : tag_q;
    inflight_d = issue;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      tag_q <= '0;
      inflight_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
      fault_q <= fault_d;
    end
  end
  // data returning on a redirect edge belongs to the wrong path
  assign push = inflight_q & ~redirect_valid;
  assign inst_valid = count != 2'd0;
  assign imem_addr = word_idx(pc_q);
  assign fetch_fault = fault_q;
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stall_q;
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fetched_q <= '0;
      stall_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(pop);
      stall_q <= stall_q + 32'(inst_valid & ~inst_ready);
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus fault, redirect and reset sequences
module tb_fetch_sequencer;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc, redirect_pc;
  logic inst_valid, inst_ready, redirect_valid, halt_req, fetch_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  logic [31:0] mem [256];
  int tests = 0;
  int fails = 0;

  fetch_sequencer dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .fetch_fault   (fetch_fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) imem_rdata <= mem[imem_addr[7:0]];

  typedef struct {
    logic rdy;
    logic redir;
    logic [31:0] rpc;
    logic halt;
    logic v;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;
  vec_t vt [27];

  function automatic vec_t mkv(input logic rdy, input logic redir, input logic [31:0] rpc,
                               input logic halt, input logic v, input logic [31:0] pc,
                               input logic [31:0] addr);
    vec_t r;
    r.rdy = rdy; r.redir = redir; r.rpc = rpc; r.halt = halt;
    r.v = v; r.pc = pc; r.addr = addr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %0s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt_req = 1'b0;
    // rdy redir rpc halt | valid pc addr ; expectations are seen before inputs apply
    vt[0]  = mkv(1, 0, 0, 0, 0, 0, 0);
    vt[1]  = mkv(1, 0, 0, 0, 0, 0, 0);
    vt[2]  = mkv(1, 0, 0, 0, 0, 0, 1);
    vt[3]  = mkv(1, 0, 0, 0, 1, 32'h0, 2);
    vt[4]  = mkv(1, 0, 0, 0, 1, 32'h4, 3);
    vt[5]  = mkv(1, 0, 0, 0, 1, 32'h8, 4);
    vt[6]  = mkv(0, 0, 0, 0, 1, 32'hC, 5);
    vt[7]  = mkv(0, 0, 0, 0, 1, 32'hC, 5);
    vt[8]  = mkv(0, 0, 0, 0, 1, 32'hC, 5);
    vt[9]  = mkv(0, 0, 0, 0, 1, 32'hC, 5);
    vt[10] = mkv(0, 0, 0, 0, 1, 32'hC, 5);
    vt[11] = mkv(1, 0, 0, 0, 1, 32'hC, 5);
    vt[12] = mkv(1, 0, 0, 0, 1, 32'h10, 6);
    vt[13] = mkv(1, 0, 0, 0, 1, 32'h14, 7);
    vt[14] = mkv(0, 1, 32'h40, 0, 1, 32'h18, 8);
    vt[15] = mkv(1, 0, 0, 0, 0, 0, 16);
    vt[16] = mkv(1, 0, 0, 0, 0, 0, 17);
    vt[17] = mkv(1, 0, 0, 0, 1, 32'h40, 18);
    vt[18] = mkv(1, 0, 0, 1, 1, 32'h44, 19);
    vt[19] = mkv(1, 0, 0, 1, 1, 32'h48, 19);
    vt[20] = mkv(1, 0, 0, 1, 0, 0, 19);
    vt[21] = mkv(1, 0, 0, 1, 0, 0, 19);
    vt[22] = mkv(1, 0, 0, 0, 0, 0, 19);
    vt[23] = mkv(1, 0, 0, 0, 0, 0, 19);
    vt[24] = mkv(1, 0, 0, 0, 0, 0, 20);
    vt[25] = mkv(1, 0, 0, 0, 1, 32'h4C, 21);
    vt[26] = mkv(1, 0, 0, 0, 1, 32'h50, 22);

    repeat (2) @(posedge Clk);
    #1;
    chk("reset inst_pc", inst_pc, 32'h0);
    chk("reset inst_data", inst_data, 32'h0);
    chk("reset fault", 32'(fetch_fault), 32'h0);
    for (int i = 0; i < 27; i++) begin
      @(negedge Clk);
      Reset_n = 1'b1;
      chk($sformatf("vec%0d valid", i), 32'(inst_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("vec%0d fault", i), 32'(fetch_fault), 32'h0);
      if (vt[i].v) begin
        chk($sformatf("vec%0d inst_pc", i), inst_pc, vt[i].pc);
        chk($sformatf("vec%0d inst_data", i), inst_data, mem[vt[i].pc[9:2]]);
      end
      inst_ready = vt[i].rdy;
      redirect_valid = vt[i].redir;
      redirect_pc = vt[i].rpc;
      halt_req = vt[i].halt;
    end

    // run off the end of memory
    @(negedge Clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3F0;
    @(negedge Clk);
    redirect_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (inst_valid && inst_ready) begin
        chk("edge inst_pc", inst_pc, 32'h3F0 + 32'(4 * n));
        chk("edge inst_data", inst_data, mem[8'd252 + 8'(n)]);
        n++;
      end
      @(negedge Clk);
    end
    chk("edge delivered count", 32'(n), 32'd4);
    chk("edge fault set", 32'(fetch_fault), 32'h1);
    chk("edge issue stopped", imem_addr, 32'd256);
    chk("edge valid drained", 32'(inst_valid), 32'h0);

    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge Clk);
    redirect_valid = 1'b0;
    chk("clear fault", 32'(fetch_fault), 32'h0);
    chk("clear imem_addr", imem_addr, 32'h0);
    k = 0;
    while (!inst_valid && k < 10) begin
      @(negedge Clk);
      k++;
    end
    chk("resume valid", 32'(inst_valid), 32'h1);
    chk("resume inst_pc", inst_pc, 32'h0);
    chk("resume inst_data", inst_data, mem[0]);

    // reset while streaming with a fetch in flight
    repeat (2) @(negedge Clk);
    chk("pre-reset valid", 32'(inst_valid), 32'h1);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("mid reset valid", 32'(inst_valid), 32'h0);
    chk("mid reset imem_addr", imem_addr, 32'h0);
    chk("mid reset inst_pc", inst_pc, 32'h0);
    Reset_n = 1'b1;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!inst_valid && k < 10);
    chk("post reset latency", 32'(k), 32'd3);
    chk("post reset inst_pc", inst_pc, 32'h0);
    chk("post reset inst_data", inst_data, mem[0]);
    @(negedge Clk);
    chk("post reset next pc", inst_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
